branch_resolve_unit: RTL and testbench

Back-end partner of the loop-buffer fetch FSM: it records each branch prediction the front end issues and checks it against the outcome resolved in execute. On a wrong direction, wrong target or out-of-order resolution it raises `mispredict` and supplies the corrected `new_pc`, then holds off new predictions while the pipeline drains. It sits between fetch/loop-buffer (prediction producer) and execute (resolution producer).

---
 rtl/branch_resolve_unit_if.sv | 47 ++++
 rtl/branch_resolve_unit.sv | 141 ++++++++++++++
 tb/tb_branch_resolve_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Prediction/resolution/redirect bundle for branch_resolve_unit.
// The counter signals exist only when BRU_STATS_EN is defined.
interface branch_resolve_unit_if;
  // Handshake: a prediction transfers on any cycle where pred_valid && pred_ready;
  // pred_ready does not depend on pred_valid. A resolution has no backpressure
  // and is consumed only when the block is checking and holds a prediction.
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_ready;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        mispredict;
  logic [31:0] new_pc;
  logic        flush;
`ifdef BRU_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_pc, res_taken, res_target,
    input  pred_ready, mispredict, new_pc, flush,
    input  branch_count, mispredict_count
  );
  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_pc, res_taken, res_target,
    output pred_ready, mispredict, new_pc, flush,
    output branch_count, mispredict_count
  );
`else
  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_pc, res_taken, res_target,
    input  pred_ready, mispredict, new_pc, flush
  );
  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_pc, res_taken, res_target,
    output pred_ready, mispredict, new_pc, flush
  );
`endif
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues front-end predictions, checks them against execute
// outcomes, redirects on mispredict and drains. Optional counters: BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  branch_resolve_unit_if.slave    bus,
  output logic                    dbg_state_o,
  output logic [$clog2(DEPTH):0]  dbg_count_o
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {CHECK = 1'b0, FLUSH = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            mispredict_q, mispredict_d;
  logic [31:0]     new_pc_q, new_pc_d;

  logic [31:0]     pc_mem    [DEPTH];
  logic            taken_mem [DEPTH];
  logic [31:0]     tgt_mem   [DEPTH];

  logic            pred_ready;
  logic            push;
  logic            compare;
  logic            mismatch;

  assign pred_ready = (state_q == CHECK) && (count_q < CW'(DEPTH));
  assign push       = bus.pred_valid && pred_ready;
  assign compare    = (state_q == CHECK) && bus.res_valid && (count_q != '0);

  // The predicted target only matters when the branch was actually taken.
  assign mismatch = compare &&
                    ((bus.res_pc    != pc_mem[rd_ptr_q])    ||
                     (bus.res_taken != taken_mem[rd_ptr_q]) ||
                     (bus.res_taken && (bus.res_target != tgt_mem[rd_ptr_q])));

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mispredict_d = 1'b0;
    new_pc_d     = new_pc_q;
    case (state_q)
      CHECK: begin
        if (mismatch) begin
          // Clearing the queue here also discards a push offered this cycle.
          state_d      = FLUSH;
          fcnt_d       = FCW'(FLUSH_CYCLES - 1);
          mispredict_d = 1'b1;
          new_pc_d     = bus.res_taken ? bus.res_target : (bus.res_pc + 32'd4);
          wr_ptr_d     = '0;
          rd_ptr_d     = '0;
          count_d      = '0;
        end else begin
          if (push)    wr_ptr_d = wr_ptr_q + AW'(1);
          if (compare) rd_ptr_d = rd_ptr_q + AW'(1);
          count_d = count_q + CW'(push) - CW'(compare);
        end
      end
      FLUSH: begin
        if (fcnt_q == '0) state_d = CHECK;
        else              fcnt_d  = fcnt_q - FCW'(1);
      end
      default: state_d = CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CHECK;
      fcnt_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      new_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
      new_pc_q     <= new_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= bus.pred_pc;
      taken_mem[wr_ptr_q] <= bus.pred_taken;
      tgt_mem[wr_ptr_q]   <= bus.pred_target;
    end
  end

  assign bus.pred_ready = pred_ready;
  assign bus.mispredict = mispredict_q;
  assign bus.new_pc     = new_pc_q;
  assign bus.flush      = (state_q == FLUSH);
  assign dbg_state_o    = logic'(state_q);
  assign dbg_count_o    = count_q;

`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (compare && (branch_cnt_q != '1))   branch_cnt_d  = branch_cnt_q + 32'd1;
    if (mismatch && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.branch_count     = branch_cnt_q;
  assign bus.mispredict_count = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (DEPTH=4, FLUSH_CYCLES=2); also covers
// the counters when BRU_STATS_EN is defined.
module tb_branch_resolve_unit;

  logic       clk;
  logic       reset;
  logic       dbg_state;
  logic [2:0] dbg_count;
  int         total;
  int         bad;

  branch_resolve_unit_if bus ();

  branch_resolve_unit #(.DEPTH(4), .FLUSH_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state),
    .dbg_count_o (dbg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input logic pv, input logic [31:0] ppc, input logic pt,
                     input logic [31:0] ptg, input logic rv, input logic [31:0] rpc,
                     input logic rt, input logic [31:0] rtg);
    bus.pred_valid  = pv;
    bus.pred_pc     = ppc;
    bus.pred_taken  = pt;
    bus.pred_target = ptg;
    bus.res_valid   = rv;
    bus.res_pc      = rpc;
    bus.res_taken   = rt;
    bus.res_target  = rtg;
    @(posedge clk);
    #1;
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    cyc(1'b1, pc, t, tg, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, pc, t, tg);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;

    // Reset state
    chk("rst_mispredict", bus.mispredict, 32'd0);
    chk("rst_new_pc", bus.new_pc, 32'd0);
    chk("rst_flush", bus.flush, 32'd0);
    chk("rst_ready", bus.pred_ready, 32'd1);
    chk("rst_count", dbg_count, 32'd0);
    chk("rst_state", dbg_state, 32'd0);

    // Loop hit: four identical predictions, all correct
    for (int i = 0; i < 4; i++) begin
      push(32'h11C, 1'b1, 32'h100);
      chk("hit_push_count", dbg_count, 32'(i + 1));
    end
    chk("hit_full_ready", bus.pred_ready, 32'd0);
    for (int i = 0; i < 4; i++) begin
      resolve(32'h11C, 1'b1, 32'h100);
      chk("hit_mispredict", bus.mispredict, 32'd0);
      chk("hit_pop_count", dbg_count, 32'(3 - i));
    end
    chk("hit_ready_end", bus.pred_ready, 32'd1);
`ifdef BRU_STATS_EN
    chk("hit_branch_count", bus.branch_count, 32'd4);
    chk("hit_mp_count", bus.mispredict_count, 32'd0);
`endif

    // Loop exit: predicted taken, actually falls through
    push(32'h11C, 1'b1, 32'h100);
    resolve(32'h11C, 1'b0, 32'h100);
    chk("exit_mispredict", bus.mispredict, 32'd1);
    chk("exit_new_pc", bus.new_pc, 32'h120);
    chk("exit_flush1", bus.flush, 32'd1);
    chk("exit_ready1", bus.pred_ready, 32'd0);
    chk("exit_count", dbg_count, 32'd0);
    // A push and a mismatching resolution during FLUSH are both ignored
    cyc(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 32'h700, 1'b1, 32'h800);
    chk("exit_pulse_end", bus.mispredict, 32'd0);
    chk("exit_flush2", bus.flush, 32'd1);
    chk("exit_ready2", bus.pred_ready, 32'd0);
    chk("exit_flush_count", dbg_count, 32'd0);
    idle();
    chk("exit_flush_done", bus.flush, 32'd0);
    chk("exit_ready_back", bus.pred_ready, 32'd1);
    chk("exit_no_mp", bus.mispredict, 32'd0);
    chk("exit_count_end", dbg_count, 32'd0);

    // Wrong target
    push(32'h10C, 1'b1, 32'h100);
    resolve(32'h10C, 1'b1, 32'h104);
    chk("tgt_mispredict", bus.mispredict, 32'd1);
    chk("tgt_new_pc", bus.new_pc, 32'h104);
    idle();
    idle();
    chk("tgt_recovered", bus.pred_ready, 32'd1);
`ifdef BRU_STATS_EN
    chk("tgt_branch_count", bus.branch_count, 32'd6);
    chk("tgt_mp_count", bus.mispredict_count, 32'd2);
`endif

    // Full and simultaneous push/pop
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 1'b0, 32'h0);
    chk("full_count", dbg_count, 32'd4);
    chk("full_ready", bus.pred_ready, 32'd0);
    push(32'h210, 1'b0, 32'h0);
    chk("full_refused", dbg_count, 32'd4);
    // Not-taken match: the resolved target must be ignored
    resolve(32'h200, 1'b0, 32'hDEAD_BEEF);
    chk("full_pop_mp", bus.mispredict, 32'd0);
    chk("full_pop_count", dbg_count, 32'd3);
    chk("full_reopen", bus.pred_ready, 32'd1);
    cyc(1'b1, 32'h210, 1'b0, 32'h0, 1'b1, 32'h204, 1'b0, 32'h0);
    chk("simul_mp", bus.mispredict, 32'd0);
    chk("simul_count", dbg_count, 32'd3);
    push(32'h214, 1'b0, 32'h0);
    chk("refill_count", dbg_count, 32'd4);
    // Drain in order to confirm the refused push never landed
    resolve(32'h208, 1'b0, 32'h0);
    resolve(32'h20C, 1'b0, 32'h0);
    resolve(32'h210, 1'b0, 32'h0);
    chk("order_mp", bus.mispredict, 32'd0);
    chk("order_count", dbg_count, 32'd1);

    // Wrap: head is 0x214, resolution names 0xFFFFFFFC not taken
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("wrap_mispredict", bus.mispredict, 32'd1);
    chk("wrap_new_pc", bus.new_pc, 32'h0000_0000);
    chk("wrap_flush", bus.flush, 32'd1);
`ifdef BRU_STATS_EN
    chk("wrap_branch_count", bus.branch_count, 32'd12);
    chk("wrap_mp_count", bus.mispredict_count, 32'd3);
`endif

    // Reset in the first FLUSH cycle
    reset = 1'b1;
    idle();
    reset = 1'b0;
    chk("rst2_flush", bus.flush, 32'd0);
    chk("rst2_ready", bus.pred_ready, 32'd1);
    chk("rst2_count", dbg_count, 32'd0);
    chk("rst2_mispredict", bus.mispredict, 32'd0);
    chk("rst2_new_pc", bus.new_pc, 32'd0);
`ifdef BRU_STATS_EN
    chk("rst2_branch_count", bus.branch_count, 32'd0);
    chk("rst2_mp_count", bus.mispredict_count, 32'd0);
`endif

    // Resolution with an empty queue changes nothing
    resolve(32'h300, 1'b1, 32'h400);
    chk("empty_mp", bus.mispredict, 32'd0);
    chk("empty_new_pc", bus.new_pc, 32'd0);
    chk("empty_flush", bus.flush, 32'd0);
    chk("empty_ready", bus.pred_ready, 32'd1);

    // Push offered in the same cycle as a mismatch is dropped
    push(32'h400, 1'b1, 32'h480);
    cyc(1'b1, 32'h404, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 32'h490);
    chk("drop_mispredict", bus.mispredict, 32'd1);
    chk("drop_new_pc", bus.new_pc, 32'h490);
    chk("drop_count", dbg_count, 32'd0);
    idle();
    idle();
    chk("drop_ready", bus.pred_ready, 32'd1);
    chk("drop_count_end", dbg_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
